// File: rtl/icache.sv
// Direct-mapped word-line instruction cache; optional hit/miss counters under ICACHE_STATS_EN.
// Latency: hit returns 1 cycle after request; miss returns 1 cycle after ic_mem_valid.
// Backpressure: rdy_in low freezes all state; if_req/if_addr ignored while a miss is outstanding.
module icache #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic        ic_mem_ask,
    output logic [31:0] ic_mem_addr,
    input  logic        ic_mem_valid,
    input  logic [31:0] ic_mem_inst,
    input  logic        rob_clear,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int TAG_BITS = 30 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_MISS = 1'b1;

    logic                  state_q, state_d;
    logic                  if_valid_q, if_valid_d;
    logic [31:0]           if_inst_q, if_inst_d;
    logic                  ask_q, ask_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [INDEX_BITS-1:0] miss_idx_q, miss_idx_d;
    logic [TAG_BITS-1:0]   miss_tag_q, miss_tag_d;
    logic                  drop_q, drop_d;
    logic [LINES-1:0]      valid_q, valid_d;

    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [31:0]           data_mem [LINES];

    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  req_hit;
    logic                  fill_we;
    logic                  hit_evt;
    logic                  miss_evt;
    logic                  unused_addr_bits;

    assign req_idx          = if_addr[INDEX_BITS+1:2];
    assign req_tag          = if_addr[31:INDEX_BITS+2];
    assign req_hit          = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign unused_addr_bits = ^if_addr[1:0];

    always_comb begin
        state_d    = state_q;
        if_valid_d = if_valid_q;
        if_inst_d  = if_inst_q;
        ask_d      = ask_q;
        mem_addr_d = mem_addr_q;
        miss_idx_d = miss_idx_q;
        miss_tag_d = miss_tag_q;
        drop_d     = drop_q;
        valid_d    = valid_q;
        fill_we    = 1'b0;
        hit_evt    = 1'b0;
        miss_evt   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (if_req && !rob_clear) begin
                    if (req_hit) begin
                        if_valid_d = 1'b1;
                        if_inst_d  = data_mem[req_idx];
                        hit_evt    = 1'b1;
                    end else begin
                        if_valid_d = 1'b0;
                        ask_d      = 1'b1;
                        mem_addr_d = {if_addr[31:2], 2'b00};
                        miss_idx_d = req_idx;
                        miss_tag_d = req_tag;
                        drop_d     = 1'b0;
                        state_d    = ST_MISS;
                        miss_evt   = 1'b1;
                    end
                end else begin
                    if_valid_d = 1'b0;
                end
            end
            default: begin
                if_valid_d = 1'b0;
                if (rob_clear) begin
                    drop_d = 1'b1;
                end
                // The fill always lands, even when the requester was flushed away.
                if (ic_mem_valid) begin
                    fill_we             = 1'b1;
                    valid_d[miss_idx_q] = 1'b1;
                    ask_d               = 1'b0;
                    if (!drop_q && !rob_clear) begin
                        if_valid_d = 1'b1;
                        if_inst_d  = ic_mem_inst;
                    end
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            if_valid_q <= 1'b0;
            if_inst_q  <= 32'd0;
            ask_q      <= 1'b0;
            mem_addr_q <= 32'd0;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
            drop_q     <= 1'b0;
            valid_q    <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            if_valid_q <= if_valid_d;
            if_inst_q  <= if_inst_d;
            ask_q      <= ask_d;
            mem_addr_q <= mem_addr_d;
            miss_idx_q <= miss_idx_d;
            miss_tag_q <= miss_tag_d;
            drop_q     <= drop_d;
            valid_q    <= valid_d;
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk_in) begin
        if (rdy_in && fill_we) begin
            tag_mem[miss_idx_q]  <= miss_tag_q;
            data_mem[miss_idx_q] <= ic_mem_inst;
        end
    end

    assign if_valid    = if_valid_q;
    assign if_inst     = if_inst_q;
    assign ic_mem_ask  = ask_q;
    assign ic_mem_addr = mem_addr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_evt  ? hit_cnt_q  + 32'd1 : hit_cnt_q;
        miss_cnt_d = miss_evt ? miss_cnt_q + 32'd1 : miss_cnt_q;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else if (rdy_in) begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = hit_evt ^ miss_evt;
    assign hit_cnt      = 32'd0;
    assign miss_cnt     = 32'd0;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hits, conflicts, flushes, stall, async reset, stats.
module tb_icache;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_inst;
    logic        ic_mem_ask;
    logic [31:0] ic_mem_addr;
    logic        ic_mem_valid;
    logic [31:0] ic_mem_inst;
    logic        rob_clear;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int checks   = 0;
    int failures = 0;

    icache #(.INDEX_BITS(6)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_valid    (if_valid),
        .if_inst     (if_inst),
        .ic_mem_ask  (ic_mem_ask),
        .ic_mem_addr (ic_mem_addr),
        .ic_mem_valid(ic_mem_valid),
        .ic_mem_inst (ic_mem_inst),
        .rob_clear   (rob_clear),
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
    );

    always #5 clk_in = ~clk_in;

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Issue a one-cycle request and return the memory word after 'lat' cycles of ask.
    task automatic do_miss(input logic [31:0] addr, input logic [31:0] data, input int lat);
        if_addr = addr;
        if_req  = 1'b1;
        tick();
        if_req = 1'b0;
        for (int i = 1; i < lat; i++) tick();
        ic_mem_valid = 1'b1;
        ic_mem_inst  = data;
        tick();
        ic_mem_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_in = 1'b1; rdy_in = 1'b1; if_req = 1'b0; if_addr = 32'd0;
        ic_mem_valid = 1'b0; ic_mem_inst = 32'd0; rob_clear = 1'b0;
        #3;
        checks++;
        if ({if_valid, ic_mem_ask} !== 2'b00 || if_inst !== 32'd0 || ic_mem_addr !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%0b ask=%0b inst=%h addr=%h want all zero",
                     if_valid, ic_mem_ask, if_inst, ic_mem_addr);
        end
        checks++;
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_counters: hit=%0d miss=%0d want 0 0", hit_cnt, miss_cnt);
        end
        tick(); tick();
        rst_in = 1'b0;
        tick();
    endtask

    task automatic test_cold_miss();
        if_addr = 32'h0000_0010;
        if_req  = 1'b1;
        tick();
        if_req = 1'b0;
        checks++;
        if (ic_mem_ask !== 1'b1 || ic_mem_addr !== 32'h10 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL cold_ask: ask=%0b addr=%h valid=%0b want 1 00000010 0",
                     ic_mem_ask, ic_mem_addr, if_valid);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (ic_mem_ask !== 1'b1 || if_valid !== 1'b0) begin
                failures++;
                $display("FAIL cold_wait%0d: ask=%0b valid=%0b want 1 0", i, ic_mem_ask, if_valid);
            end
        end
        ic_mem_valid = 1'b1;
        ic_mem_inst  = 32'h0000_0093;
        tick();
        ic_mem_valid = 1'b0;
        checks++;
        if (if_valid !== 1'b1 || if_inst !== 32'h93 || ic_mem_ask !== 1'b0) begin
            failures++;
            $display("FAIL cold_return: valid=%0b inst=%h ask=%0b want 1 00000093 0",
                     if_valid, if_inst, ic_mem_ask);
        end
        tick();
        checks++;
        if (if_valid !== 1'b0 || ic_mem_ask !== 1'b0) begin
            failures++;
            $display("FAIL cold_single_pulse: valid=%0b ask=%0b want 0 0", if_valid, ic_mem_ask);
        end
    endtask

    task automatic test_hit_after_fill();
        logic [31:0] exp_hits;
        logic [31:0] exp_miss;
        if_addr = 32'h0000_0010;
        if_req  = 1'b1;
        tick();
        checks++;
        if (if_valid !== 1'b1 || if_inst !== 32'h93 || ic_mem_ask !== 1'b0) begin
            failures++;
            $display("FAIL hit_first: valid=%0b inst=%h ask=%0b want 1 00000093 0",
                     if_valid, if_inst, ic_mem_ask);
        end
        tick();
        if_req = 1'b0;
        checks++;
        if (if_valid !== 1'b1 || if_inst !== 32'h93) begin
            failures++;
            $display("FAIL hit_second: valid=%0b inst=%h want 1 00000093", if_valid, if_inst);
        end
        tick();
        checks++;
        if (if_valid !== 1'b0) begin
            failures++;
            $display("FAIL hit_idle: valid=%0b want 0", if_valid);
        end
`ifdef ICACHE_STATS_EN
        exp_hits = 32'd2;
        exp_miss = 32'd1;
`else
        exp_hits = 32'd0;
        exp_miss = 32'd0;
`endif
        checks++;
        if (hit_cnt !== exp_hits || miss_cnt !== exp_miss) begin
            failures++;
            $display("FAIL stats: hit=%0d miss=%0d want %0d %0d", hit_cnt, miss_cnt, exp_hits, exp_miss);
        end
    endtask

    task automatic test_back_to_back();
        do_miss(32'h0000_0014, 32'h0000_0113, 2);
        if_req  = 1'b1;
        if_addr = 32'h0000_0010;
        tick();
        if_addr = 32'h0000_0014;
        checks++;
        if (if_valid !== 1'b1 || if_inst !== 32'h93) begin
            failures++;
            $display("FAIL b2b_first: valid=%0b inst=%h want 1 00000093", if_valid, if_inst);
        end
        tick();
        if_req = 1'b0;
        checks++;
        if (if_valid !== 1'b1 || if_inst !== 32'h113 || ic_mem_ask !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second: valid=%0b inst=%h ask=%0b want 1 00000113 0",
                     if_valid, if_inst, ic_mem_ask);
        end
        tick();
    endtask

    task automatic test_conflict();
        if_addr = 32'h0000_0110;
        if_req  = 1'b1;
        tick();
        if_req = 1'b0;
        checks++;
        if (ic_mem_ask !== 1'b1 || ic_mem_addr !== 32'h110 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL conflict_miss: ask=%0b addr=%h valid=%0b want 1 00000110 0",
                     ic_mem_ask, ic_mem_addr, if_valid);
        end
        tick();
        ic_mem_valid = 1'b1;
        ic_mem_inst  = 32'hAAAA_0001;
        tick();
        ic_mem_valid = 1'b0;
        checks++;
        if (if_valid !== 1'b1 || if_inst !== 32'hAAAA_0001) begin
            failures++;
            $display("FAIL conflict_fill: valid=%0b inst=%h want 1 aaaa0001", if_valid, if_inst);
        end
        tick();
        if_addr = 32'h0000_0010;
        if_req  = 1'b1;
        tick();
        if_req = 1'b0;
        checks++;
        if (ic_mem_ask !== 1'b1 || ic_mem_addr !== 32'h10 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL conflict_remiss: ask=%0b addr=%h valid=%0b want 1 00000010 0",
                     ic_mem_ask, ic_mem_addr, if_valid);
        end
        ic_mem_valid = 1'b1;
        ic_mem_inst  = 32'h0000_0093;
        tick();
        ic_mem_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush_miss();
        int seen;
        seen    = 0;
        if_addr = 32'h0000_0020;
        if_req  = 1'b1;
        tick();
        if_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rob_clear = (i == 1);
            tick();
            if (ic_mem_ask !== 1'b1) seen++;
            if (if_valid !== 1'b0) seen++;
        end
        rob_clear    = 1'b0;
        ic_mem_valid = 1'b1;
        ic_mem_inst  = 32'h0000_2222;
        tick();
        ic_mem_valid = 1'b0;
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL flush_hold: violations=%0d want 0 (ask held, valid low)", seen);
        end
        checks++;
        if (if_valid !== 1'b0 || ic_mem_ask !== 1'b0) begin
            failures++;
            $display("FAIL flush_dropped: valid=%0b ask=%0b want 0 0", if_valid, ic_mem_ask);
        end
        tick();
        if_req = 1'b1;
        tick();
        if_req = 1'b0;
        checks++;
        if (if_valid !== 1'b1 || if_inst !== 32'h2222 || ic_mem_ask !== 1'b0) begin
            failures++;
            $display("FAIL flush_later_hit: valid=%0b inst=%h ask=%0b want 1 00002222 0",
                     if_valid, if_inst, ic_mem_ask);
        end
        tick();
    endtask

    task automatic test_flush_hit();
        if_addr   = 32'h0000_0010;
        if_req    = 1'b1;
        rob_clear = 1'b1;
        tick();
        if_req    = 1'b0;
        rob_clear = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || ic_mem_ask !== 1'b0) begin
            failures++;
            $display("FAIL flush_hit: valid=%0b ask=%0b want 0 0", if_valid, ic_mem_ask);
        end
        tick();
    endtask

    task automatic test_stall();
        if_addr = 32'h0000_0030;
        if_req  = 1'b1;
        tick();
        if_req = 1'b0;
        tick();
        rdy_in       = 1'b0;
        ic_mem_valid = 1'b1;
        ic_mem_inst  = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ic_mem_ask !== 1'b1 || ic_mem_addr !== 32'h30 || if_valid !== 1'b0) begin
                failures++;
                $display("FAIL stall_frozen%0d: ask=%0b addr=%h valid=%0b want 1 00000030 0",
                         i, ic_mem_ask, ic_mem_addr, if_valid);
            end
        end
        rdy_in       = 1'b1;
        ic_mem_valid = 1'b0;
        tick();
        ic_mem_valid = 1'b1;
        ic_mem_inst  = 32'h0000_0333;
        tick();
        ic_mem_valid = 1'b0;
        checks++;
        if (if_valid !== 1'b1 || if_inst !== 32'h333 || ic_mem_ask !== 1'b0) begin
            failures++;
            $display("FAIL stall_resume: valid=%0b inst=%h ask=%0b want 1 00000333 0",
                     if_valid, if_inst, ic_mem_ask);
        end
        tick();
    endtask

    task automatic test_async_reset();
        if_addr = 32'h0000_0040;
        if_req  = 1'b1;
        tick();
        if_req = 1'b0;
        tick();
        #1;
        rst_in = 1'b1;
        #1;
        checks++;
        if (ic_mem_ask !== 1'b0 || ic_mem_addr !== 32'd0) begin
            failures++;
            $display("FAIL async_reset: ask=%0b addr=%h want 0 00000000", ic_mem_ask, ic_mem_addr);
        end
        tick();
        rst_in  = 1'b0;
        if_addr = 32'h0000_0010;
        if_req  = 1'b1;
        tick();
        if_req = 1'b0;
        checks++;
        if (ic_mem_ask !== 1'b1 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_invalidates: ask=%0b valid=%0b want 1 0", ic_mem_ask, if_valid);
        end
        ic_mem_valid = 1'b1;
        ic_mem_inst  = 32'h0000_0093;
        tick();
        ic_mem_valid = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_after_fill();
        test_back_to_back();
        test_conflict();
        test_flush_miss();
        test_flush_hit();
        test_stall();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
